// File: rtl/ntt_butterfly_pipe.sv
// Fixed-latency modular Cooley-Tukey butterfly over a serial hi/lo operand stream.
// Define NTT_BFLY_CHECK_EN to build the sticky range/protocol error flag on err.

module ntt_butterfly_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD     = 12289,
  parameter int unsigned LATENCY = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] tw_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              pair_hi,
  output logic              err
);

  localparam int unsigned W   = DATA_W;
  localparam int unsigned PW  = 2 * DATA_W;
  localparam int unsigned M_W = PW - $clog2(MOD) + 1;
  localparam int unsigned QW  = PW + M_W;
  localparam int unsigned DLY = LATENCY - 8;
  localparam longint unsigned BM_FULL = (64'd1 << PW) / 64'(MOD);
  localparam logic [M_W-1:0] BARRETT_M = M_W'(BM_FULL);
  localparam logic [W-1:0]   MOD_W     = W'(MOD);
  localparam logic [PW-1:0]  MOD_P     = PW'(MOD);

  // Control: phase and the (valid, is_hi) shift register
  logic                 r_phase_lo;
  logic [LATENCY-2:0]   r_vld;
  logic [LATENCY-2:0]   r_ishi;
  logic                 w_broken;

  // Datapath registers (no reset needed)
  logic [W-1:0]   r_hi, r_tw;
  logic [W-1:0]   r_lo1, r_lo2, r_lo3, r_lo4;
  logic [PW-1:0]  r_prod, r_x;
  logic [M_W-1:0] r_q;
  logic [W-1:0]   r_r, r_t;
  logic [W-1:0]   r_sum;
  logic [W:0]     r_dif;
  logic [W-1:0]   r_hip, r_lop;
  logic [W-1:0]   r_lo_hold;

  logic [QW-1:0]  w_qm;
  logic [PW-1:0]  w_qmod;
  logic [W-1:0]   w_hip_d, w_lop_d;

  // A hi word not followed immediately by its lo word abandons the pair
  assign w_broken = r_phase_lo & ~in_valid;

  assign w_qm   = QW'(r_prod) * QW'(BARRETT_M);
  assign w_qmod = PW'(r_q) * MOD_P;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_lo <= 1'b0;
      r_vld      <= '0;
      r_ishi     <= '0;
      out_valid  <= 1'b0;
      pair_hi    <= 1'b0;
      out_data   <= '0;
    end else begin
      r_phase_lo <= in_valid & ~r_phase_lo;
      r_vld      <= {r_vld[LATENCY-3:1], r_vld[0] & ~w_broken, in_valid};
      r_ishi     <= {r_ishi[LATENCY-3:0], ~r_phase_lo};
      out_valid  <= r_vld[LATENCY-2];
      pair_hi    <= r_vld[LATENCY-2] & r_ishi[LATENCY-2];
      if (r_vld[LATENCY-2]) begin
        out_data <= r_ishi[LATENCY-2] ? w_hip_d : r_lo_hold;
      end
    end
  end

  // Free-running arithmetic: each stage holds a given pair for exactly the cycle it is needed.
  // Barrett with k = 2*DATA_W leaves the remainder in [0, 2*MOD) for any product, so one
  // conditional subtract is exact.
  always_ff @(posedge clk) begin
    if (in_valid && !r_phase_lo) begin
      r_hi <= in_data;
      r_tw <= tw_in;
    end
    r_lo1  <= in_data;
    r_prod <= PW'(r_hi) * PW'(r_tw);
    r_lo2  <= r_lo1;
    r_x    <= r_prod;
    r_q    <= M_W'(w_qm >> PW);
    r_lo3  <= r_lo2;
    r_r    <= W'(r_x - w_qmod);
    r_lo4  <= r_lo3;
    r_t    <= (r_r >= MOD_W) ? (r_r - MOD_W) : r_r;
    r_sum  <= r_lo4 + r_t;
    r_dif  <= {1'b0, r_lo4} - {1'b0, r_t};
    r_lop  <= (r_sum >= MOD_W) ? (r_sum - MOD_W) : r_sum;
    r_hip  <= r_dif[W] ? W'(r_dif + {1'b0, MOD_W}) : r_dif[W-1:0];
    r_lo_hold <= w_lop_d;
  end

  // Pad the result pair out to the configured latency
  generate
    if (DLY == 0) begin : g_nodly
      assign w_hip_d = r_hip;
      assign w_lop_d = r_lop;
    end else begin : g_dly
      logic [2*W-1:0] r_pair [DLY];
      always_ff @(posedge clk) begin
        r_pair[0] <= {r_hip, r_lop};
        for (int i = 1; i < int'(DLY); i++) begin
          r_pair[i] <= r_pair[i-1];
        end
      end
      assign {w_hip_d, w_lop_d} = r_pair[DLY-1];
    end
  endgenerate

`ifdef NTT_BFLY_CHECK_EN
  logic r_err;
  logic w_bad_in;

  assign w_bad_in = in_valid & ((in_data >= MOD_W) | (~r_phase_lo & (tw_in >= MOD_W)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad_in || w_broken) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Bench for ntt_butterfly_pipe: slot-indexed expectation model plus literal pins.

module tb_ntt_butterfly_pipe;

  localparam int DW  = 16;
  localparam int Q   = 12289;
  localparam int L   = 11;
  localparam int NS  = 4096;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] tw_in = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          pair_hi;
  logic          err;

  ntt_butterfly_pipe #(.DATA_W(DW), .MOD(Q), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .tw_in(tw_in),
    .out_valid(out_valid), .out_data(out_data), .pair_hi(pair_hi), .err(err)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  // Model: expected output per slot (slot = ecnt value while the output is visible)
  bit          ev [NS];
  logic [15:0] ed [NS];
  bit          eh [NS];
  bit          ec [NS];
  int          err_slot = BIG;
  bit          m_lo = 1'b0;
  int          m_hi, m_tw, m_hk;
  bit          m_care;

  int          n_lit = 0;
  int          lit_slot [32];
  logic [15:0] lit_data [32];
  bit          lit_hi [32];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, int slot, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s slot %0d: got %0d expected %0d", name, slot, act, exp);
    end
  endfunction

  function automatic void sched(int s, bit hi, int d, bit care);
    if (s < NS) begin
      ev[s] = 1'b1;
      ed[s] = 16'(d);
      eh[s] = hi;
      ec[s] = care;
    end
  endfunction

  function automatic void note_err(int s);
    if (s < err_slot) err_slot = s;
  endfunction

  task automatic word(input bit v, input int d, input int w);
    int t, hip, lop;
    bit care;
    @(posedge clk); #1;
    in_valid = v;
    in_data  = 16'(d);
    tw_in    = 16'(w);
    if (v) begin
      if (!m_lo) begin
        m_hi = d; m_tw = w; m_hk = ecnt; m_lo = 1'b1;
        m_care = (d < Q) && (w < Q);
        if (!m_care) note_err(ecnt + 1);
      end else begin
        care = m_care && (d < Q);
        t   = int'((longint'(m_hi) * longint'(m_tw)) % longint'(Q));
        lop = (d + t) % Q;
        hip = (d + Q - t) % Q;
        sched(m_hk + L, 1'b1, hip, care);
        sched(m_hk + L + 1, 1'b0, lop, care);
        m_lo = 1'b0;
        if (d >= Q) note_err(ecnt + 1);
      end
    end else if (m_lo) begin
      m_lo = 1'b0;
      note_err(ecnt + 1);
    end
  endtask

  task automatic pair(input int h, input int w, input int l);
    word(1'b1, h, w);
    word(1'b1, l, 0);
  endtask

  // Hand-computed results for the most recent pair
  task automatic lit2(input int dh, input int dl);
    lit_slot[n_lit] = m_hk + L;     lit_data[n_lit] = 16'(dh); lit_hi[n_lit] = 1'b1; n_lit++;
    lit_slot[n_lit] = m_hk + L + 1; lit_data[n_lit] = 16'(dl); lit_hi[n_lit] = 1'b0; n_lit++;
  endtask

  // Reset with in_valid held high to show reset wins over input
  task automatic do_rst(input int n);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 16'd5; tw_in = 16'd7;
    m_lo = 1'b0;
    err_slot = BIG;
    for (int s = ecnt; s < NS; s++) ev[s] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  // Compare process
  initial begin
    int j;
    bit ev_j, eh_j, err_j, known;
    logic [15:0] hold;
    known = 1'b1;
    hold  = '0;
    forever begin
      @(negedge clk);
      j = ecnt;
      if (j < NS) begin
        ev_j = !rst && ev[j];
        eh_j = ev_j && eh[j];
`ifdef NTT_BFLY_CHECK_EN
        err_j = !rst && (j >= err_slot);
`else
        err_j = 1'b0;
`endif
        if (rst) begin
          hold = '0; known = 1'b1;
        end else if (ev_j) begin
          known = ec[j];
          hold  = ed[j];
        end
        chk("out_valid", j, int'(out_valid), int'(ev_j));
        chk("pair_hi", j, int'(pair_hi), int'(eh_j));
        chk("err", j, int'(err), int'(err_j));
        if (known) chk("out_data", j, int'(out_data), int'(hold));
        for (int i = 0; i < n_lit; i++) begin
          if (lit_slot[i] == j) begin
            chk("lit_valid", j, int'(out_valid), 1);
            chk("lit_pair_hi", j, int'(pair_hi), int'(lit_hi[i]));
            chk("lit_data", j, int'(out_data), int'(lit_data[i]));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    pair(2, 3, 10);           lit2(4, 16);
    word(1'b0, 0, 0);
    word(1'b0, 0, 0);
    pair(1, 1, 12288);        lit2(12287, 0);
    pair(12288, 12288, 0);    lit2(12288, 1);
    repeat (3) word(1'b0, 0, 0);

    // Broken pair, then a clean pair
    word(1'b1, 100, 200);
    word(1'b0, 0, 0);
    pair(5, 6, 7);            lit2(12266, 37);
    repeat (2) word(1'b0, 0, 0);

    for (int i = 0; i < 128; i++)
      pair(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
           int'($urandom_range(0, Q - 1)));
    repeat (L + 2) word(1'b0, 0, 0);

    // Reset on the sixth word of a stream
    pair(11, 22, 33);
    pair(44, 55, 66);
    word(1'b1, 77, 88);
    do_rst(2);
    pair(3, 4, 20);           lit2(8, 32);
    repeat (L + 2) word(1'b0, 0, 0);

    // Out-of-range twiddle, then out-of-range lo
    do_rst(2);
    pair(100, Q + 5, 50);
    pair(9, 9, 81);           lit2(0, 162);
    repeat (L + 2) word(1'b0, 0, 0);
    do_rst(2);
    pair(7, 7, Q + 1);
    pair(1000, 2000, 3000);
    repeat (L + 4) word(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
